// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule: expands one cipher key into 11 round keys, one per cycle,
// then serves any round key from the store through a registered read port (forward or reverse order).
module key_expansion_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [127:0] key,
   input  logic         keyValid,
   output logic         keyReady,
   output logic         busy,
   output logic         expandDone,
   input  logic         decrypt,
   input  logic [3:0]   roundIndex,
   output logic [127:0] roundKey
);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   state_t        state;
   state_t        nextState;
   logic [127:0]  rk [NUM_ROUNDS+1];
   logic [7:0]    rcon;
   logic [3:0]    idx;
   logic [3:0]    prevIdx;
   logic [3:0]    readIdx;
   logic          accept;
   logic [127:0]  prevKey;
   logic [31:0]   rotWord;
   logic [31:0]   temp;
   logic [31:0]   w0;
   logic [31:0]   w1;
   logic [31:0]   w2;
   logic [31:0]   w3;
   logic [127:0]  nextKey;

   assign accept = keyValid && keyReady;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = EXPAND;
         EXPAND:  if (idx == LAST_ROUND) nextState = DONE;
         DONE:    if (accept) nextState = EXPAND;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      keyReady   = 1'b1;
      busy       = 1'b0;
      expandDone = 1'b0;
      case (state)
         EXPAND: begin
            keyReady = 1'b0;
            busy     = 1'b1;
         end
         DONE:    expandDone = 1'b1;
         default: ;
      endcase
   end

   // One round of the schedule: derive rk[idx] from rk[idx-1] with the current rcon.
   always_comb begin
      prevIdx = (idx == 4'd0) ? 4'd0 : idx - 4'd1;
      prevKey = rk[prevIdx];
      w3      = prevKey[31:0];
      rotWord = {w3[23:0], w3[31:24]};
      temp    = {SBOX[rotWord[31:24]], SBOX[rotWord[23:16]],
                 SBOX[rotWord[15:8]],  SBOX[rotWord[7:0]]} ^ {rcon, 24'h0};
      w0      = prevKey[127:96] ^ temp;
      w1      = prevKey[95:64] ^ w0;
      w2      = prevKey[63:32] ^ w1;
      nextKey = {w0, w1, w2, w3 ^ w2};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            rk[i] <= '0;
         end
         rcon <= 8'h00;
         idx  <= 4'd0;
      end else if (accept) begin
         rk[0] <= key;
         rcon  <= 8'h01;
         idx   <= 4'd1;
      end else if (state == EXPAND) begin
         rk[idx] <= nextKey;
         rcon    <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         idx     <= idx + 4'd1;
      end
   end

   // Reverse order for decryption; anything past the last round reads as zero.
   assign readIdx = decrypt ? LAST_ROUND - roundIndex : roundIndex;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         roundKey <= '0;
      end else if (expandDone && (roundIndex <= LAST_ROUND)) begin
         roundKey <= rk[readIdx];
      end else begin
         roundKey <= '0;
      end
   end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: FIPS-197 and zero-key vectors plus random keys checked
// against a word-level key schedule built on an S-box derived from GF(2^8) arithmetic.
module tb_key_expansion_seq;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [127:0] key;
   logic         keyValid;
   logic         keyReady;
   logic         busy;
   logic         expandDone;
   logic         decrypt;
   logic [3:0]   roundIndex;
   logic [127:0] roundKey;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sboxRef [256];
   logic [127:0] modelRk [11];

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

   key_expansion_seq #(.NUM_ROUNDS(10)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .key        (key),
      .keyValid   (keyValid),
      .keyReady   (keyReady),
      .busy       (busy),
      .expandDone (expandDone),
      .decrypt    (decrypt),
      .roundIndex (roundIndex),
      .roundKey   (roundKey)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box = affine transform of the multiplicative inverse.
   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic modelExpand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sboxRef[t[31:24]], sboxRef[t[23:16]], sboxRef[t[15:8]], sboxRef[t[7:0]]} ^ {rc, 24'h0};
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) modelRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [127:0] k, input logic v, input logic d, input logic [3:0] ri);
      key        = k;
      keyValid   = v;
      decrypt    = d;
      roundIndex = ri;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic loadKey(input logic [127:0] k);
      applyStimulus(k, 1'b1, decrypt, roundIndex);
      tick();
      keyValid = 1'b0;
   endtask

   // Bounded wait for expandDone, counting edges since the accept edge.
   task automatic waitDone(input string tag, input int start);
      int n = start;
      while (!expandDone && n < 40) begin
         tick();
         n++;
      end
      checkOutput(tag, 128'(n), 128'd10);
   endtask

   task automatic readCheck(input string tag, input logic d, input logic [3:0] ri);
      logic [127:0] exp;
      decrypt    = d;
      roundIndex = ri;
      tick();
      if (ri <= 4'd10) exp = modelRk[d ? 10 - int'(ri) : int'(ri)];
      else             exp = '0;
      checkOutput(tag, roundKey, exp);
   endtask

   initial begin
      logic [127:0] k;
      buildSbox();
      applyStimulus('0, 1'b0, 1'b0, 4'd0);
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #10;
      checkOutput("rstRoundKey", roundKey, '0);
      checkOutput("rstKeyReady", 128'(keyReady), 128'd1);
      checkOutput("rstBusy", 128'(busy), 128'd0);
      checkOutput("rstDone", 128'(expandDone), 128'd0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      $display("[TB] FIPS-197 key with busy-time key pulse");
      modelExpand(FIPS_KEY);
      applyStimulus(FIPS_KEY, 1'b0, 1'b0, 4'd3);
      loadKey(FIPS_KEY);
      checkOutput("e0Busy", 128'(busy), 128'd1);
      checkOutput("e0KeyReady", 128'(keyReady), 128'd0);
      tick();
      tick();
      tick();
      applyStimulus(~FIPS_KEY, 1'b1, 1'b0, 4'd3);
      tick();
      keyValid = 1'b0;
      checkOutput("busyKeyReady", 128'(keyReady), 128'd0);
      checkOutput("earlyRead", roundKey, '0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("e9Done", 128'(expandDone), 128'd0);
      tick();
      checkOutput("e10Done", 128'(expandDone), 128'd1);
      checkOutput("e10Busy", 128'(busy), 128'd0);
      checkOutput("e10KeyReady", 128'(keyReady), 128'd1);
      decrypt = 1'b0;
      roundIndex = 4'd0;
      tick();
      checkOutput("fipsRk0", roundKey, FIPS_KEY);
      roundIndex = 4'd1;
      tick();
      checkOutput("fipsRk1", roundKey, FIPS_RK1);
      roundIndex = 4'd10;
      tick();
      checkOutput("fipsRk10", roundKey, FIPS_RK10);
      roundIndex = 4'd12;
      tick();
      checkOutput("outOfRange", roundKey, '0);
      for (int i = 0; i < 16; i++) readCheck("fipsSweep", i[0] ^ i[2], 4'(i));

      $display("[TB] re-key from DONE with zero key");
      modelExpand('0);
      applyStimulus(FIPS_KEY, 1'b0, 1'b0, 4'd10);
      loadKey('0);
      checkOutput("rekeyDoneLow", 128'(expandDone), 128'd0);
      tick();
      checkOutput("rekeyReadZero", roundKey, '0);
      waitDone("rekeyLatency", 1);
      decrypt = 1'b1;
      roundIndex = 4'd0;
      tick();
      checkOutput("zeroRevIdx0", roundKey, ZERO_RK10);
      roundIndex = 4'd9;
      tick();
      checkOutput("zeroRevIdx9", roundKey, ZERO_RK1);

      $display("[TB] reset mid-expansion");
      k = {$urandom, $urandom, $urandom, $urandom};
      loadKey(k);
      for (int i = 0; i < 5; i++) tick();
      reset_n = 1'b0;
      #1;
      checkOutput("midRstBusy", 128'(busy), 128'd0);
      checkOutput("midRstKeyReady", 128'(keyReady), 128'd1);
      checkOutput("midRstRoundKey", roundKey, '0);
      checkOutput("midRstDone", 128'(expandDone), 128'd0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      checkOutput("postRstKeyReady", 128'(keyReady), 128'd1);
      modelExpand(k);
      loadKey(k);
      waitDone("postRstLatency", 0);
      for (int i = 0; i < 6; i++) readCheck("postRstRead", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

      $display("[TB] random keys");
      for (int n = 0; n < 5; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         modelExpand(k);
         loadKey(k);
         waitDone("randLatency", 0);
         for (int i = 0; i < 8; i++) readCheck("randRead", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
